seq_gen: RTL



---
 rtl/seq_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// Serial frame transmitter: sync preamble, LSB-first payload, optional even parity, idle gap.
// Latency: the first preamble bit is on data_o in the cycle after the accepting edge.
// Backpressure: in_ready_o is high only while idle; words are refused for the whole frame and gap.
// Optional even-parity bit after the payload: define SEQ_GEN_PARITY_EN.
module seq_gen #(
  parameter int                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = 4'b1011,
  parameter int                 DATA_LEN    = 8,
  parameter int                 GAP_LEN     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [DATA_LEN-1:0] in_data_i,
  output logic                in_ready_o,
  output logic                data_o,
  output logic                tx_active_o,
  output logic                done_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int MAX_LEN = (SEQ_LEN > DATA_LEN) ?
                           ((SEQ_LEN > GAP_LEN) ? SEQ_LEN : GAP_LEN) :
                           ((DATA_LEN > GAP_LEN) ? DATA_LEN : GAP_LEN);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] SEQ_LAST  = CNT_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  // With no gap configured a finished frame falls straight back to IDLE.
  localparam state_t AFTER_FRAME = (GAP_LEN > 0) ? GAP : IDLE;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_LEN-1:0] word_q;
  logic                frame_end;
  logic                line_bit;
  logic                active_nxt;
  logic                pat_bit;
  logic                word_bit;

  assign in_ready_o = (state == IDLE);

  // Bit selects via mask so every pattern/word bit is consumed and the counter width never matters.
  assign pat_bit  = |(SEQ_PATTERN & (SEQ_LEN'(1) << cnt_nxt));
  assign word_bit = |(word_q & (DATA_LEN'(1) << cnt_nxt));

  // State and bit counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: counter clears on every state change, frame_end marks the last frame bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in_valid_i) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        if (cnt == SEQ_LAST) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = '0;
        end
      end
      PAYLOAD: begin
        if (cnt == DATA_LAST) begin
          cnt_nxt = '0;
`ifdef SEQ_GEN_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = AFTER_FRAME;
          frame_end = 1'b1;
`endif
        end
      end
      PARITY: begin
        state_nxt = AFTER_FRAME;
        cnt_nxt   = '0;
        frame_end = 1'b1;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Line value for the upcoming cycle, decoded from where the FSM is heading.
  always_comb begin
    line_bit   = 1'b0;
    active_nxt = 1'b0;
    case (state_nxt)
      PREAMBLE: begin
        line_bit   = pat_bit;
        active_nxt = 1'b1;
      end
      PAYLOAD: begin
        line_bit   = word_bit;
        active_nxt = 1'b1;
      end
      PARITY: begin
        line_bit   = ^word_q;
        active_nxt = 1'b1;
      end
      default: begin
        line_bit   = 1'b0;
        active_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs, payload latch on the handshake, and the completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q      <= '0;
      data_o      <= 1'b0;
      tx_active_o <= 1'b0;
      done_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      if (state == IDLE && in_valid_i) word_q <= in_data_i;
      data_o      <= line_bit;
      tx_active_o <= active_nxt;
      done_o      <= frame_end;
      if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule
